// File: rtl/mem_stage_ctrl_if.sv
// Pipeline-side handshake bundle for the memory-stage sequencing controller.
// master = pipeline (drives hazard/ME inputs), slave = controller (drives stalls/flushes).
interface mem_stage_ctrl_if;
    logic       me_dm_write;
    logic [1:0] me_ru_data_src;
    logic       me_valid;
    logic [1:0] ex_ru_data_src;
    logic       ex_ru_write;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       branch_taken;
    logic       dm_req;
    logic       dm_we;
    logic       stall_if;
    logic       stall_id;
    logic       stall_ex;
    logic       stall_me;
    logic       bubble_wb;
    logic       flush_id;
    logic       flush_ex;
    logic       busy;

    modport master (
        output me_dm_write, me_ru_data_src, me_valid, ex_ru_data_src, ex_ru_write,
               ex_rd, id_rs1, id_rs2, branch_taken,
        input  dm_req, dm_we, stall_if, stall_id, stall_ex, stall_me, bubble_wb,
               flush_id, flush_ex, busy
    );

    modport slave (
        input  me_dm_write, me_ru_data_src, me_valid, ex_ru_data_src, ex_ru_write,
               ex_rd, id_rs1, id_rs2, branch_taken,
        output dm_req, dm_we, stall_if, stall_id, stall_ex, stall_me, bubble_wb,
               flush_id, flush_ex, busy
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Stall/flush sequencer for the 5-stage core: memory wait states, load-use and branch flush.
// Optional MEM_STAGE_PERF_EN adds saturating stall-cycle and flush counters.
module mem_stage_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_stage_ctrl_if.slave   bus
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [15:0]       stall_cycle_cnt,
    output logic [15:0]       flush_cnt
`endif
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic {IDLE, WAIT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_op;
    logic             mem_stall;
    logic             load_use;

    assign mem_op   = bus.me_valid & (bus.me_dm_write | (bus.me_ru_data_src == 2'b01));
    assign load_use = (bus.ex_ru_data_src == 2'b01) & bus.ex_ru_write & (bus.ex_rd != 5'd0)
                    & ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Access stalls in IDLE on arrival and in WAIT until cnt reaches zero (completion cycle).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && (WAIT_CYCLES != 0)) begin
                    mem_stall = 1'b1;
                    state_d   = WAIT;
                    cnt_d     = CNT_W'(WAIT_CYCLES - 1);
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Prioritised pipeline control; everything held low while rst is asserted.
    always_comb begin
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.stall_if  = 1'b0;
        bus.stall_id  = 1'b0;
        bus.stall_ex  = 1'b0;
        bus.stall_me  = 1'b0;
        bus.bubble_wb = 1'b0;
        bus.flush_id  = 1'b0;
        bus.flush_ex  = 1'b0;
        bus.busy      = 1'b0;
        if (!rst) begin
            bus.dm_req = mem_op;
            bus.dm_we  = mem_op & bus.me_dm_write;
            bus.busy   = (state_q == WAIT);
            if (mem_stall) begin
                bus.stall_if  = 1'b1;
                bus.stall_id  = 1'b1;
                bus.stall_ex  = 1'b1;
                bus.stall_me  = 1'b1;
                bus.bubble_wb = 1'b1;
            end else if (bus.branch_taken) begin
                bus.flush_id = 1'b1;
                bus.flush_ex = 1'b1;
            end else if (load_use) begin
                bus.stall_if = 1'b1;
                bus.stall_id = 1'b1;
                bus.flush_ex = 1'b1;
            end
        end
    end

`ifdef MEM_STAGE_PERF_EN
    logic [15:0] stall_cycle_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        stall_any;
    logic        flush_any;

    assign stall_any = bus.stall_if | bus.stall_id | bus.stall_ex | bus.stall_me;
    assign flush_any = bus.flush_id | bus.flush_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycle_cnt_q <= '0;
            flush_cnt_q       <= '0;
        end else begin
            if (stall_any && (stall_cycle_cnt_q != '1)) stall_cycle_cnt_q <= stall_cycle_cnt_q + 16'd1;
            if (flush_any && (flush_cnt_q != '1))       flush_cnt_q       <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cycle_cnt = stall_cycle_cnt_q;
    assign flush_cnt       = flush_cnt_q;
`endif
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus random traffic vs. a cycle-count model.
module tb_mem_stage_ctrl;
    localparam int unsigned W = 2;

    logic clk;
    logic rst;
    mem_stage_ctrl_if bus ();

    int n_checks = 0;
    int n_fails  = 0;
    int pos      = 0;  // cycles the current access has spent in ME; 0 = no access in progress

`ifdef MEM_STAGE_PERF_EN
    logic [15:0] stall_cycle_cnt;
    logic [15:0] flush_cnt;
    mem_stage_ctrl #(.WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus),
                                           .stall_cycle_cnt(stall_cycle_cnt), .flush_cnt(flush_cnt));
`else
    mem_stage_ctrl #(.WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {dm_req, dm_we, stall_if, stall_id, stall_ex, stall_me, bubble_wb, flush_id, flush_ex, busy}
    logic [9:0] outs;
    assign outs = {bus.dm_req, bus.dm_we, bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_me,
                   bus.bubble_wb, bus.flush_id, bus.flush_ex, bus.busy};

    function automatic logic cur_mem_op();
        return bus.me_valid && (bus.me_dm_write || bus.me_ru_data_src == 2'b01);
    endfunction

    function automatic logic [9:0] model_out();
        logic [9:0] r;
        logic mop, stall, lu;
        r = '0;
        if (rst) return r;
        mop   = cur_mem_op();
        stall = (pos > 0) ? (pos < int'(W)) : (mop && W > 0);
        lu    = bus.ex_ru_data_src == 2'b01 && bus.ex_ru_write && bus.ex_rd != 0 &&
                (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
        r[9] = mop;
        r[8] = mop && bus.me_dm_write;
        r[0] = pos > 0;
        if (stall)                 r[7:3] = 5'b11111;
        else if (bus.branch_taken) r[2:1] = 2'b11;
        else if (lu)               begin r[7] = 1'b1; r[6] = 1'b1; r[1] = 1'b1; end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst)                         pos = 0;
        else if (pos > 0)                pos = (pos >= int'(W)) ? 0 : pos + 1;
        else if (cur_mem_op() && W > 0)  pos = 1;
        #1;
    endtask

    task automatic set_in(input logic mv, input logic dw, input logic [1:0] src,
                          input logic [1:0] exsrc, input logic exw, input logic [4:0] exrd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic br);
        bus.me_valid = mv; bus.me_dm_write = dw; bus.me_ru_data_src = src;
        bus.ex_ru_data_src = exsrc; bus.ex_ru_write = exw; bus.ex_rd = exrd;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.branch_taken = br;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        rst = 1'b1;
        set_in(1, 0, 2'b01, 2'b01, 1, 5'd5, 5'd5, 5'd0, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 10'b0) begin
                n_fails++; $display("FAIL reset cyc%0d got=%b exp=%b", i, outs, 10'b0);
            end
            tick();
        end
        rst = 1'b0;
        set_in(0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
        @(negedge clk);
        exp = model_out();
        n_checks++;
        if (outs !== exp) begin n_fails++; $display("FAIL reset_release got=%b exp=%b", outs, exp); end
        tick();
    endtask

    task automatic test_single_load();
        logic [9:0] exp;
        int st = 0, rq = 0, we = 0, bb = 0, bs = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_in(1, 0, 2'b01, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            else       set_in(0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            @(negedge clk);
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin n_fails++; $display("FAIL single_load cyc%0d got=%b exp=%b", i, outs, exp); end
            st += int'(bus.stall_me); rq += int'(bus.dm_req); we += int'(bus.dm_we);
            bb += int'(bus.bubble_wb); bs += int'(bus.busy);
            tick();
        end
        n_checks++;
        if (st != 2 || rq != 3 || we != 0 || bb != 2 || bs != 2) begin
            n_fails++;
            $display("FAIL single_load_counts stall=%0d req=%0d we=%0d bubble=%0d busy=%0d exp 2/3/0/2/2", st, rq, we, bb, bs);
        end
    endtask

    task automatic test_store_load();
        logic [9:0] exp;
        int st = 0, rq = 0, we = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 3)      set_in(1, 1, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            else if (i < 6) set_in(1, 0, 2'b01, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            else            set_in(0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            @(negedge clk);
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin n_fails++; $display("FAIL store_load cyc%0d got=%b exp=%b", i, outs, exp); end
            st += int'(bus.stall_me); rq += int'(bus.dm_req); we += int'(bus.dm_we);
            tick();
        end
        n_checks++;
        if (st != 4 || rq != 6 || we != 3) begin
            n_fails++; $display("FAIL store_load_counts stall=%0d req=%0d we=%0d exp 4/6/3", st, rq, we);
        end
    endtask

    task automatic test_load_use();
        set_in(0, 0, 2'b00, 2'b01, 1, 5'd5, 5'd1, 5'd5, 0);
        @(negedge clk);
        n_checks++;
        if (outs !== 10'b0011000010) begin
            n_fails++; $display("FAIL load_use got=%b exp=%b", outs, 10'b0011000010);
        end
        tick();
        set_in(0, 0, 2'b00, 2'b01, 1, 5'd0, 5'd0, 5'd0, 0);
        @(negedge clk);
        n_checks++;
        if (outs !== 10'b0) begin n_fails++; $display("FAIL load_use_x0 got=%b exp=%b", outs, 10'b0); end
        tick();
    endtask

    task automatic test_branch();
        logic [9:0] exp;
        set_in(0, 0, 2'b00, 2'b01, 1, 5'd7, 5'd7, 5'd0, 1);
        @(negedge clk);
        n_checks++;
        if (outs !== 10'b0000000110) begin
            n_fails++; $display("FAIL branch_lu got=%b exp=%b", outs, 10'b0000000110);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 2'b01, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1);
            @(negedge clk);
            exp = (i < 2) ? ((i == 0) ? 10'b1011111000 : 10'b1011111001) : 10'b1000000111;
            n_checks++;
            if (outs !== exp) begin n_fails++; $display("FAIL branch_in_stall cyc%0d got=%b exp=%b", i, outs, exp); end
            tick();
        end
        set_in(0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
        @(negedge clk);
        exp = model_out();
        n_checks++;
        if (outs !== exp) begin n_fails++; $display("FAIL branch_after got=%b exp=%b", outs, exp); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [9:0] exp;
        int st = 0;
        for (int i = 0; i < 4; i++) begin
            rst = (i == 2);
            if (i < 3) set_in(1, 0, 2'b01, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            else       set_in(0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            @(negedge clk);
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin n_fails++; $display("FAIL rst_mid_wait cyc%0d got=%b exp=%b", i, outs, exp); end
            if (i >= 2 && outs !== 10'b0) begin
                n_fails++; $display("FAIL rst_mid_wait_zero cyc%0d got=%b exp=%b", i, outs, 10'b0);
            end
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_in(1, 0, 2'b01, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            else       set_in(0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            @(negedge clk);
            st += int'(bus.stall_me);
            tick();
        end
        n_checks++;
        if (st != 2) begin n_fails++; $display("FAIL rst_then_load stall=%0d exp=2", st); end
    endtask

    task automatic test_random();
        logic [9:0] exp;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            set_in(1'($urandom), 1'($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom_range(0, 1)),
                   1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0));
            @(negedge clk);
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin n_fails++; $display("FAIL random cyc%0d got=%b exp=%b", i, outs, exp); end
            tick();
        end
        rst = 1'b0;
    endtask

`ifdef MEM_STAGE_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        set_in(0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) set_in(1, 0, 2'b01, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            else       set_in(0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
            tick();
        end
        n_checks++;
        if (stall_cycle_cnt !== 16'd6 || flush_cnt !== 16'd0) begin
            n_fails++; $display("FAIL perf stall=%0d flush=%0d exp 6/0", stall_cycle_cnt, flush_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        set_in(0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0);
        test_reset();
        test_single_load();
        test_store_load();
        test_load_use();
        test_branch();
        test_reset_mid_wait();
        test_random();
`ifdef MEM_STAGE_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Pipeline sequencing controller for the five-stage RISC-V core.
- Owns stall and flush of the IF/ID, ID/EX and EX/ME pipeline registers.
- Stretches data-memory accesses sitting in the EX/ME register across a fixed number of wait states.
- Detects load-use hazards and taken-branch flushes.
- State updates on the rising edge of clk; all stall/flush outputs are combinational and settle before the pipeline registers capture on the falling edge.

Parameters:
WAIT_CYCLES, 2, stall cycles per data-memory access (0..15); 0 = single-cycle memory, never stalls.

Ports:
clk  input  1  clock; FSM and counters update on rising edge
rst  input  1  synchronous, active-high reset
me_dm_write  input  1  EX/ME dm_write (store in ME)
me_ru_data_src  input  2  EX/ME ru_data_src; 2'b01 = load in ME
me_valid  input  1  ME stage holds a real instruction (not a bubble)
ex_ru_data_src  input  2  ID/EX ru_data_src; 2'b01 = load in EX
ex_ru_write  input  1  ID/EX ru_write
ex_rd  input  5  ID/EX destination register
id_rs1  input  5  IF/ID source register 1
id_rs2  input  5  IF/ID source register 2
branch_taken  input  1  EX resolved a taken branch/jump
dm_req  output  1  data-memory access active
dm_we  output  1  data-memory write strobe
stall_if  output  1  hold PC
stall_id  output  1  hold IF/ID
stall_ex  output  1  hold ID/EX
stall_me  output  1  hold EX/ME
bubble_wb  output  1  load NOP (ru_write=0) into ME/WB
flush_id  output  1  clear IF/ID to NOP
flush_ex  output  1  clear ID/EX to NOP
busy  output  1  FSM in WAIT

Behaviour:
- mem_op = me_valid & (me_dm_write | me_ru_data_src==2'b01).
- FSM states: IDLE, WAIT. Counter cnt is 4 bits.
- IDLE with mem_op and WAIT_CYCLES>0:
  - mem_stall=1 this cycle.
  - Next state WAIT; cnt <= WAIT_CYCLES-1.
- WAIT:
  - mem_stall = (cnt!=0).
  - If cnt!=0: cnt <= cnt-1.
  - If cnt==0: next state IDLE; the access completes and the pipeline advances this cycle.
- Total stall per access = WAIT_CYCLES cycles; access occupies WAIT_CYCLES+1 cycles.
- Back-to-back memory ops: the op arriving in ME after the completion cycle is caught in IDLE the same cycle, with no idle gap.
- dm_req = mem_op & (state==WAIT | IDLE). dm_we = dm_req & me_dm_write.
- busy = (state==WAIT).
- load_use = ex_ru_data_src==2'b01 & ex_ru_write & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Priority, highest first:
  1. mem_stall: stall_if=stall_id=stall_ex=stall_me=1, bubble_wb=1, flush_id=flush_ex=0. branch_taken and load_use are ignored; both persist because EX is frozen and are re-evaluated after release.
  2. branch_taken: flush_id=1, flush_ex=1, all stalls 0. Any simultaneous load_use is discarded because the dependent instruction is flushed.
  3. load_use: stall_if=1, stall_id=1, flush_ex=1 (one bubble); stall_ex=stall_me=0.
  4. Otherwise all outputs 0.
- WAIT_CYCLES==0: FSM stays in IDLE; dm_req = mem_op; mem_stall is never asserted.
- Reset:
  - rst high at a rising edge forces state=IDLE, cnt=0, aborting any in-flight access.
  - While rst is high, every output is forced to 0.
  - After release, outputs follow the rules above from IDLE.

Optional Feature:
MEM_STAGE_PERF_EN
- Defined: adds output ports stall_cycle_cnt[15:0] and flush_cnt[15:0].
  - stall_cycle_cnt increments on every rising edge where any stall output is 1.
  - flush_cnt increments on every rising edge where flush_id | flush_ex is 1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- WAIT_CYCLES=2, single load in ME (me_valid=1, me_ru_data_src=01) -> stall_me=1 for exactly 2 cycles, dm_req=1 for 3 cycles, dm_we=0, bubble_wb=1 during the 2 stall cycles, busy=1 for 2 cycles.
- Store followed immediately by load (WAIT_CYCLES=2) -> dm_we=1 only for the store's 3 cycles; load stalls 2 more cycles with no gap; 4 stall cycles total.
- Load in EX with ex_rd=5, id_rs2=5, no mem op -> one cycle of stall_if=stall_id=flush_ex=1; same case with ex_rd=0 -> no stall.
- branch_taken=1 together with load_use -> flush_id=flush_ex=1, stall_if=0; branch_taken=1 during mem_stall -> no flush until the completion cycle, then flush_id=flush_ex=1.
- rst asserted in the second cycle of WAIT -> next cycle busy=0 and all outputs 0; after release, a new load produces the full 2 stall cycles.
- MEM_STAGE_PERF_EN defined, 3 back-to-back loads with WAIT_CYCLES=2 -> stall_cycle_cnt=6, flush_cnt=0; counter preloaded near saturation holds at 16'hFFFF.
